mips_data_mem: RTL and testbench
================================

# mips_data_mem

Data-memory responder for the pipelined MIPS core: the memory side of the `memread`/`memwrite` interface that the CPU's MEM stage drives.
- Services one word-aligned read or write at a time with a parameterised access latency.
- Holds the pipeline via `stall` until the access completes.
- Returns registered read data and flags illegal requests.

## Interface
Parameters:
- `DATA_W`, 32, data word width.
- `DEPTH`, 256, memory depth in words; power of two.
- `LATENCY`, 2, access latency in cycles; legal range 1..15.

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memread`  in  1  read request from the MEM stage.
- `memwrite`  in  1  write request from the MEM stage.
- `addr`  in  32  byte address; must be word aligned.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  read data of the last completed read.
- `stall`  out  1  freeze the pipeline while an access is in progress.
- `err`  out  1  sticky error flag.

## Operation
- Word index is `addr[2 +: log2(DEPTH)]`. Upper address bits are ignored, so addresses alias modulo DEPTH words.
- A request is `memread | memwrite`. It is legal when `addr[1:0]==0`.
- State machine: IDLE, BUSY, DONE.
  - **IDLE, legal request:**
    - Capture `addr`, `wdata` and op.
    - If LATENCY==1: perform the access and go to DONE.
    - Otherwise: load `cnt <= LATENCY-2` and go to BUSY.
  - **IDLE, misaligned request:** no access, no stall, set `err`, stay in IDLE.
  - **BUSY:**
    - If `cnt==0`: perform the access using the captured values and go to DONE.
    - Otherwise: decrement `cnt`.
  - **DONE:** go to IDLE unconditionally.
    - A request present during DONE is the one completing and does not re-trigger.
- Access semantics:
  - Write: `mem[idx] <= wdata_q`.
  - Read: `rdata <= mem[idx]`.
  - `rdata` holds its value until the next read completes; writes do not change it.
- `memread` and `memwrite` both high: treated as a write, and `err` is set.
- Inputs are sampled only in IDLE. Changes to inputs during BUSY or DONE are ignored.
- `stall` is combinational: `(state==IDLE & legal request) | state==BUSY`.
- Memory contents are not reset.

## Timing
- Reset values: state=IDLE, `cnt`=0, `rdata`=0, `err`=0. `stall`=0 whenever no legal request is present.
- Request accepted in cycle 0:
  - `stall` is high in cycles 0..LATENCY-1 and low in cycle LATENCY (DONE).
  - Read data is valid in `rdata` from cycle LATENCY.
  - Write data is visible to a read accepted in cycle LATENCY+1.
- Minimum spacing between two accepted requests is LATENCY+1 cycles.
- Back-to-back pattern: DONE is followed by IDLE, which accepts the next request in that same cycle.
- Reset during BUSY: abort. The pending write is discarded, `rdata` is cleared and `stall` drops in the cycle after the reset edge.
- `err` is set on the edge after the offending IDLE cycle and is cleared only by `rst`.

## Structure
- Package `mips_mem_pkg` holds:
  - state enum `mem_state_t` {IDLE, BUSY, DONE};
  - constant `WORD_OFF = 2`;
  - function `clog2` for index width.
- Sub-module `mem_array`: single-port synchronous RAM.
  - Ports: `clk`, `we`, `re`, `idx`, `wd`, `rd`.
  - No reset.
  - Read data registered in the same edge as the access.
- Top level: FSM, counter, capture registers, error logic.
- Expected size: about 150 lines total.

## Test plan
- **Reset:** hold `rst` 2 cycles with `memread=1`, `addr=0` -> `stall=0`, `rdata=0`, `err=0` throughout.
- **Write then read (LATENCY=2):**
  - Write 0xDEADBEEF to 0x10 at cycle 0 -> `stall` high in cycles 0–1, low in cycle 2.
  - Read 0x10 accepted at cycle 3 -> `rdata=0xDEADBEEF` at cycle 5, with `stall` high in cycles 3–4.
- **LATENCY=1 build:** read request at cycle 0 -> `stall` high only in cycle 0; data valid at cycle 1; next request accepted at cycle 2.
- **Aliasing, DEPTH=256:**
  - Write 0x11111111 to 0x000, then 0x22222222 to 0x400.
  - Read 0x000 -> `rdata=0x22222222`.
- **Errors:**
  - Read at 0x13 -> no stall, `err=1` next cycle, `rdata` unchanged.
  - `memread=memwrite=1` at 0x20 with `wdata=0x5` -> write performed, `err=1`; subsequent read of 0x20 returns 0x5.
- **Reset mid-access:**
  - Write 0xAAAA to 0x40 (old value 0x1234); assert `rst` in cycle 1 of BUSY.
  - Expect `stall` low after reset, `err=0`.
  - A later read of 0x40 returns 0x1234.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Byte-to-word shift: the low two address bits select a byte within a word.
    localparam int WORD_OFF = 2;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM; read data is registered on the access edge.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wd;
        if (re) rd <= mem[idx];
    end

endmodule

// File: rtl/mips_data_mem.sv
// Data-memory responder for the MEM stage: one word access at a time,
// LATENCY cycles long, with a pipeline stall and a sticky error flag.
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err,
    output mem_state_t        dbg_state
);

    localparam int IDX_W = clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    mem_state_t        state, state_nxt;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              rd_valid;

    logic              req, aligned, legal, accept;
    logic              access, acc_write;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wd;
    logic [DATA_W-1:0] rd_raw;
    logic              unused_addr;

    assign req     = memread | memwrite;
    assign aligned = (addr[1:0] == 2'b00);
    assign legal   = req & aligned;
    assign accept  = (state == IDLE) & legal;

    // Handshake: the MEM stage holds memread/memwrite/addr/wdata while stall is
    // high; the request is taken in the IDLE cycle it appears and stall drops in
    // the DONE cycle, where rdata already carries the result of a read.
    assign stall = ~rst & (accept | (state == BUSY));

    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        acc_write = write_q;
        acc_idx   = idx_q;
        acc_wd    = wdata_q;
        case (state)
            IDLE: begin
                if (legal) begin
                    if (LATENCY == 1) begin
                        // Single-cycle build: access straight from the inputs.
                        state_nxt = DONE;
                        access    = 1'b1;
                        acc_write = memwrite;
                        acc_idx   = addr[WORD_OFF +: IDX_W];
                        acc_wd    = wdata;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    access    = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) cnt <= CNT_INIT;
            else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == IDLE && req && (!aligned || (memread && memwrite))) err <= 1'b1;
            if (access && !acc_write) rd_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= addr[WORD_OFF +: IDX_W];
            wdata_q <= wdata;
            write_q <= memwrite;
        end
    end

    // Reset aborts an in-flight access, so a pending write never lands.
    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk (clk),
        .we  (access & acc_write & ~rst),
        .re  (access & ~acc_write & ~rst),
        .idx (acc_idx),
        .wd  (acc_wd),
        .rd  (rd_raw)
    );

    assign rdata       = rd_valid ? rd_raw : '0;
    assign dbg_state   = state;
    assign unused_addr = ^addr[31:WORD_OFF+IDX_W];

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_mips_data_mem;
    import mips_mem_pkg::*;

    logic        clk;
    logic        rst;

    logic        rd2, wr2;
    logic [31:0] ad2, wd2, rdata2;
    logic        stall2, err2;
    mem_state_t  st2;

    logic        rd1, wr1;
    logic [31:0] ad1, wd1, rdata1;
    logic        stall1, err1;
    mem_state_t  st1;

    int n_assert;
    int n_fail;

    mips_data_mem #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .memread(rd2), .memwrite(wr2), .addr(ad2),
        .wdata(wd2), .rdata(rdata2), .stall(stall2), .err(err2), .dbg_state(st2)
    );

    mips_data_mem #(.DATA_W(32), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .memread(rd1), .memwrite(wr1), .addr(ad1),
        .wdata(wd1), .rdata(rdata1), .stall(stall1), .err(err1), .dbg_state(st1)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: a cycle starts 1 time unit after the rising edge; checks
    // land mid-cycle, well away from either clock edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive2(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd2 = r; wr2 = w; ad2 = a; wd2 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd1 = r; wr1 = w; ad1 = a; wd1 = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full LATENCY=2 access: request in cycle 0, stall in 0..1, DONE in 2.
    // Returns mid-way through the DONE cycle.
    task automatic access2(input string tag, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        next_cycle(); drive2(r, w, a, d); settle();
        chk({tag, "_stall_c0"}, 32'(stall2), 32'd1);
        next_cycle(); drive2(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0); settle();
        chk({tag, "_stall_c1"}, 32'(stall2), 32'd1);
        next_cycle(); settle();
        chk({tag, "_stall_done"}, 32'(stall2), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive2(1'b1, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held two cycles with a read request present
        for (int i = 0; i < 2; i++) begin
            next_cycle(); settle();
            chk("rst_stall", 32'(stall2), 32'd0);
            chk("rst_rdata", rdata2, 32'h0);
            chk("rst_err",   32'(err2), 32'd0);
        end
        chk("rst_state", 32'(st2), 32'(IDLE));
        chk("rst_rdata_l1", rdata1, 32'h0);
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;

        // Write then read
        access2("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        chk("wr10_rdata_kept", rdata2, 32'h0);
        chk("wr10_state_done", 32'(st2), 32'(DONE));
        access2("rd10", 1'b1, 1'b0, 32'h10, 32'h0);
        chk("rd10_rdata", rdata2, 32'hDEAD_BEEF);
        chk("rd10_err", 32'(err2), 32'd0);

        // Aliasing modulo 256 words
        access2("wr000", 1'b0, 1'b1, 32'h000, 32'h1111_1111);
        access2("wr400", 1'b0, 1'b1, 32'h400, 32'h2222_2222);
        access2("rd000", 1'b1, 1'b0, 32'h000, 32'h0);
        chk("alias_rdata", rdata2, 32'h2222_2222);
        access2("rd10b", 1'b1, 1'b0, 32'h10, 32'h0);
        chk("rd10b_rdata", rdata2, 32'hDEAD_BEEF);

        // Misaligned read
        next_cycle(); drive2(1'b1, 1'b0, 32'h13, 32'h0); settle();
        chk("mis_stall", 32'(stall2), 32'd0);
        chk("mis_err_before", 32'(err2), 32'd0);
        next_cycle(); drive2(1'b0, 1'b0, 32'h0, 32'h0); settle();
        chk("mis_err_after", 32'(err2), 32'd1);
        chk("mis_rdata_kept", rdata2, 32'hDEAD_BEEF);
        chk("mis_state", 32'(st2), 32'(IDLE));

        // Read and write together: performed as a write, err stays set
        access2("both20", 1'b1, 1'b1, 32'h20, 32'h5);
        chk("both20_rdata_kept", rdata2, 32'hDEAD_BEEF);
        access2("rd20", 1'b1, 1'b0, 32'h20, 32'h0);
        chk("rd20_rdata", rdata2, 32'h5);
        chk("rd20_err", 32'(err2), 32'd1);

        // Reset in the BUSY cycle discards the pending write
        access2("wr40", 1'b0, 1'b1, 32'h40, 32'h1234);
        next_cycle(); drive2(1'b0, 1'b1, 32'h40, 32'hAAAA); settle();
        chk("abort_stall_c0", 32'(stall2), 32'd1);
        next_cycle(); drive2(1'b0, 1'b0, 32'h0, 32'h0); rst = 1'b1; settle();
        chk("abort_state_busy", 32'(st2), 32'(BUSY));
        next_cycle(); rst = 1'b0; settle();
        chk("abort_stall", 32'(stall2), 32'd0);
        chk("abort_err", 32'(err2), 32'd0);
        chk("abort_rdata", rdata2, 32'h0);
        access2("rd40", 1'b1, 1'b0, 32'h40, 32'h0);
        chk("rd40_rdata", rdata2, 32'h1234);

        // LATENCY=1 instance: stall only in the request cycle
        next_cycle(); drive1(1'b0, 1'b1, 32'h8, 32'h77); settle();
        chk("l1_wr_stall", 32'(stall1), 32'd1);
        next_cycle(); drive1(1'b0, 1'b0, 32'h0, 32'h0); settle();
        chk("l1_wr_done_stall", 32'(stall1), 32'd0);
        next_cycle(); drive1(1'b1, 1'b0, 32'h8, 32'h0); settle();
        chk("l1_rd_stall", 32'(stall1), 32'd1);
        next_cycle(); settle();
        chk("l1_rd_done_stall", 32'(stall1), 32'd0);
        chk("l1_rd_rdata", rdata1, 32'h77);
        next_cycle(); settle();
        chk("l1_next_accept", 32'(stall1), 32'd1);
        next_cycle(); drive1(1'b0, 1'b0, 32'h0, 32'h0); settle();
        chk("l1_next_done", 32'(stall1), 32'd0);
        chk("l1_err", 32'(err1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
